// File: rtl/gate_chk_pkg.sv
// ---------------------------------------------------------------------------
// gate_chk_pkg
// Shared definitions for the gate result checker: vector/observation widths,
// bit positions of each gate output inside the 7-bit observation word, and
// the checker FSM state encoding.
// ---------------------------------------------------------------------------
package gate_chk_pkg;

  localparam int VEC_W = 4;
  localparam int OBS_W = 7;

  // Observation word layout, MSB to LSB: {not, and, or, nand, nor, xor, xnor}
  localparam int NOT_B  = 6;
  localparam int AND_B  = 5;
  localparam int OR_B   = 4;
  localparam int NAND_B = 3;
  localparam int NOR_B  = 2;
  localparam int XOR_B  = 1;
  localparam int XNOR_B = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : gate_chk_pkg

// File: rtl/gate_ref_model.sv
// ---------------------------------------------------------------------------
// gate_ref_model
// Combinational golden model of the gate bank under test.
//   vec_in   [3:0] : applied inputs, bit3=in_1 .. bit0=in_4
//   expected [6:0] : expected gate outputs in the observation word layout
// The NOT gate only sees in_1; the other gates reduce all four inputs.
// ---------------------------------------------------------------------------
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [VEC_W-1:0] vec_in,
  output logic [OBS_W-1:0] expected
);

  always_comb begin
    expected         = '0;
    expected[NOT_B]  = ~vec_in[3];
    expected[AND_B]  = &vec_in;
    expected[OR_B]   = |vec_in;
    expected[NAND_B] = ~(&vec_in);
    expected[NOR_B]  = ~(|vec_in);
    expected[XOR_B]  = ^vec_in;
    expected[XNOR_B] = ~(^vec_in);
  end

endmodule : gate_ref_model

// File: rtl/gate_result_checker.sv
// ---------------------------------------------------------------------------
// gate_result_checker
// Runs a check of NUM_VECTORS applied vectors against the golden gate model,
// counting accepted and mismatching vectors and latching the first failure.
//   clk, rst        : clock, asynchronous active-high reset
//   start, abort    : begin a run (IDLE/DONE only) / abandon a run in progress
//   vec_valid       : vec_in/obs carry one vector and its observed outputs
//   vec_in, obs     : applied inputs (4b) and observed gate outputs (7b)
//   vec_ready, busy : high only in RUN (decoded from state)
//   done, pass      : run finished / finished with zero mismatches
//   vec_count       : accepted vectors (saturating)
//   err_count       : mismatching vectors (saturating)
//   first_err_vec   : vec_in of the first mismatching vector of the run
//   first_err_mask  : obs ^ expected for that vector
//   err_pulse       : one-cycle flag after each mismatching vector
// ---------------------------------------------------------------------------
module gate_result_checker
  import gate_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             vec_valid,
  input  logic [VEC_W-1:0] vec_in,
  input  logic [OBS_W-1:0] obs,
  output logic             vec_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [VEC_W-1:0] first_err_vec,
  output logic [OBS_W-1:0] first_err_mask,
  output logic             err_pulse
);

  // Run length is tracked separately from vec_count so that the end of a
  // run never depends on where the visible counter saturates.
  localparam int             RUN_W    = $clog2(NUM_VECTORS + 1);
  localparam logic [RUN_W-1:0] LAST_IDX = RUN_W'(NUM_VECTORS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_cnt;
  logic [OBS_W-1:0] expected_p0;
  logic [OBS_W-1:0] mask_p0;
  logic             accept_p0;
  logic             mismatch_p0;
  logic             last_p0;

  gate_ref_model u_ref (
    .vec_in   (vec_in),
    .expected (expected_p0)
  );

  assign busy        = (state == RUN);
  assign vec_ready   = busy;
  assign accept_p0   = vec_valid && busy;
  assign mask_p0     = obs ^ expected_p0;
  assign mismatch_p0 = |mask_p0;
  assign last_p0     = accept_p0 && (run_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)        state_nxt = IDLE;
        else if (last_p0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- accept stage -> registered result (_p1) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt        <= '0;
      vec_count      <= '0;
      err_count      <= '0;
      first_err_vec  <= '0;
      first_err_mask <= '0;
      err_pulse      <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            run_cnt        <= '0;
            vec_count      <= '0;
            err_count      <= '0;
            first_err_vec  <= '0;
            first_err_mask <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            // A vector presented on the abort cycle is dropped.
            done <= 1'b0;
            pass <= 1'b0;
          end else if (accept_p0) begin
            run_cnt   <= run_cnt + 1'b1;
            vec_count <= sat_inc(vec_count);
            if (mismatch_p0) begin
              err_pulse <= 1'b1;
              err_count <= sat_inc(err_count);
              // err_count only reaches zero again at start, so zero here
              // means this is the first failure of the run.
              if (err_count == '0) begin
                first_err_vec  <= vec_in;
                first_err_mask <= mask_p0;
              end
            end
            if (last_p0) begin
              done <= 1'b1;
              pass <= (err_count == '0) && !mismatch_p0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule : gate_result_checker

// File: tb/tb_gate_result_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_result_checker
// Directed bench for gate_result_checker. dut runs 3-vector checks with
// 8-bit counters; dut2 runs 4-vector checks with 2-bit counters to reach
// counter saturation. Inputs change on the falling edge, outputs are
// sampled on the falling edge after the rising edge that consumed them.
// ---------------------------------------------------------------------------
module tb_gate_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start = 1'b0, abort = 1'b0, vec_valid = 1'b0;
  logic [3:0] vec_in = '0;
  logic [6:0] obs = '0;
  logic       vec_ready, busy, done, pass, err_pulse;
  logic [7:0] vec_count, err_count;
  logic [3:0] first_err_vec;
  logic [6:0] first_err_mask;

  logic       start2 = 1'b0, vec_valid2 = 1'b0;
  logic [3:0] vec_in2 = '0;
  logic [6:0] obs2 = '0;
  logic       vec_ready2, busy2, done2, pass2, err_pulse2;
  logic [1:0] vec_count2, err_count2;
  logic [3:0] first_err_vec2;
  logic [6:0] first_err_mask2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_result_checker #(.NUM_VECTORS(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .vec_valid(vec_valid), .vec_in(vec_in), .obs(obs),
    .vec_ready(vec_ready), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count),
    .first_err_vec(first_err_vec), .first_err_mask(first_err_mask),
    .err_pulse(err_pulse)
  );

  gate_result_checker #(.NUM_VECTORS(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .vec_valid(vec_valid2), .vec_in(vec_in2), .obs(obs2),
    .vec_ready(vec_ready2), .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vec_count2), .err_count(err_count2),
    .first_err_vec(first_err_vec2), .first_err_mask(first_err_mask2),
    .err_pulse(err_pulse2)
  );

  task automatic chk(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply(input logic [3:0] v, input logic [6:0] o);
    vec_valid = 1'b1;
    vec_in    = v;
    obs       = o;
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic apply2(input logic [3:0] v, input logic [6:0] o);
    vec_valid2 = 1'b1;
    vec_in2    = v;
    obs2       = o;
    @(negedge clk);
    vec_valid2 = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", vec_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_vcnt", vec_count, 0);
    chk("rst_ecnt", err_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // All three vectors match
    do_start();
    chk("t1_busy", busy, 1);
    chk("t1_ready", vec_ready, 1);
    apply(4'b0000, 7'h4D);
    chk("t1_v1_cnt", vec_count, 1);
    chk("t1_v1_pulse", err_pulse, 0);
    apply(4'b0001, 7'h5A);
    chk("t1_v2_cnt", vec_count, 2);
    chk("t1_v2_pulse", err_pulse, 0);
    apply(4'b1111, 7'h31);
    chk("t1_vcnt", vec_count, 3);
    chk("t1_ecnt", err_count, 0);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_pulse", err_pulse, 0);
    chk("t1_busy_done", busy, 0);

    // One failure in the middle
    do_start();
    chk("t2_clr_vcnt", vec_count, 0);
    chk("t2_clr_done", done, 0);
    apply(4'b0000, 7'h4D);
    chk("t2_v1_pulse", err_pulse, 0);
    apply(4'b1111, 7'h33);
    chk("t2_v2_pulse", err_pulse, 1);
    chk("t2_v2_ecnt", err_count, 1);
    chk("t2_fev", first_err_vec, 4'b1111);
    chk("t2_fem", first_err_mask, 7'h02);
    apply(4'b0001, 7'h5A);
    chk("t2_v3_pulse", err_pulse, 0);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    chk("t2_ecnt", err_count, 1);

    // Two failures, first one retained
    do_start();
    chk("t3_clr_ecnt", err_count, 0);
    chk("t3_clr_fem", first_err_mask, 0);
    apply(4'b0000, 7'h4C);
    chk("t3_v1_pulse", err_pulse, 1);
    chk("t3_v1_fem", first_err_mask, 7'h01);
    apply(4'b0001, 7'h00);
    chk("t3_v2_pulse", err_pulse, 1);
    chk("t3_v2_ecnt", err_count, 2);
    chk("t3_fev", first_err_vec, 4'b0000);
    chk("t3_fem", first_err_mask, 7'h01);
    apply(4'b1111, 7'h31);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_ecnt", err_count, 2);

    // Abort coincident with an accept
    do_start();
    apply(4'b0000, 7'h4D);
    chk("t4_v1_cnt", vec_count, 1);
    abort = 1'b1;
    vec_valid = 1'b1;
    vec_in = 4'b0001;
    obs = 7'h00;
    @(negedge clk);
    abort = 1'b0;
    vec_valid = 1'b0;
    chk("t4_idle", busy, 0);
    chk("t4_vcnt", vec_count, 1);
    chk("t4_ecnt", err_count, 0);
    chk("t4_done", done, 0);
    chk("t4_pass", pass, 0);
    chk("t4_pulse", err_pulse, 0);

    // vec_valid in IDLE ignored; start in RUN ignored
    apply(4'b0000, 7'h00);
    chk("t5_idle_vcnt", vec_count, 1);
    chk("t5_idle_ecnt", err_count, 0);
    chk("t5_idle_pulse", err_pulse, 0);
    do_start();
    chk("t5_run", busy, 1);
    chk("t5_clr", vec_count, 0);
    apply(4'b0000, 7'h4D);
    do_start();
    chk("t5_no_restart", vec_count, 1);
    chk("t5_still_run", busy, 1);
    apply(4'b0001, 7'h5A);
    apply(4'b1111, 7'h31);
    chk("t5_vcnt", vec_count, 3);
    chk("t5_done", done, 1);
    chk("t5_pass", pass, 1);

    // Asynchronous reset between clock edges mid-run
    do_start();
    apply(4'b0000, 7'h4C);
    chk("t6_pre_pulse", err_pulse, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_vcnt", vec_count, 0);
    chk("t6_async_ecnt", err_count, 0);
    chk("t6_async_fem", first_err_mask, 0);
    chk("t6_async_pulse", err_pulse, 0);
    chk("t6_async_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    apply(4'b0000, 7'h4D);
    chk("t6_wait_idle", busy, 0);
    chk("t6_wait_vcnt", vec_count, 0);

    // Saturation with 2-bit counters
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("t7_busy", busy2, 1);
    for (int i = 0; i < 3; i++) apply2(4'b0000, 7'h00);
    chk("t7_ecnt3", err_count2, 3);
    chk("t7_not_done", done2, 0);
    chk("t7_fem", first_err_mask2, 7'h4D);
    apply2(4'b0000, 7'h00);
    chk("t7_ecnt_sat", err_count2, 3);
    chk("t7_vcnt_sat", vec_count2, 3);
    chk("t7_pulse", err_pulse2, 1);
    chk("t7_done", done2, 1);
    chk("t7_pass", pass2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gate_result_checker
